screen_scan_ctrl: RTL and testbench

- Framebuffer-driven scan controller for the 64-column, 32-row-pair HUB75 LED panel on the rv32i SoC.
- Fetches pixel pairs from an external synchronous-read framebuffer RAM and sequences shift/latch/blank/row timing.
- Produces BITS-per-channel colour by binary-coded modulation (BCM) across bit-planes.
- Double-buffered: the CPU requests a buffer swap, which is granted only at frame boundary.

---
 rtl/screen_pkg.sv | 29 ++
 rtl/screen_tick_gen.sv | 32 +++
 rtl/screen_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_screen_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared definitions for the HUB75 scan controller: state encoding, default
// geometry and the channel layout of a framebuffer word.
package screen_pkg;

    localparam int NUM_COLS_DEF = 64;
    localparam int ROW_BITS_DEF = 5;
    localparam int BITS_DEF     = 4;

    // Column field of the framebuffer address is always 6 bits wide.
    localparam int COL_BITS = 6;
    localparam int NUM_CHAN = 6;

    // Channel slots in a framebuffer word, counted from the LSB in units of BITS.
    localparam int FB_B1 = 0;
    localparam int FB_G1 = 1;
    localparam int FB_R1 = 2;
    localparam int FB_B0 = 3;
    localparam int FB_G0 = 4;
    localparam int FB_R0 = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_SHOW,
        ST_NEXT
    } scan_state_e;

endpackage

// File: rtl/screen_tick_gen.sv
// Divides the system clock into a one-cycle tick every CLK_DIV cycles and a
// half flag CLK_DIV/2 cycles after each tick.
module screen_tick_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic half
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign half = (cnt_q == CNT_W'(CLK_DIV / 2 - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/screen_scan_ctrl.sv
// HUB75 panel scan controller: fetches pixel pairs from a double-buffered
// framebuffer and drives shift/latch/blank/row timing with BCM bit-planes.
module screen_scan_ctrl
    import screen_pkg::*;
#(
    parameter int freq_hz    = 25000000,
    parameter int CLK_DIV    = 10,
    parameter int NUM_COLS   = NUM_COLS_DEF,
    parameter int ROW_BITS   = ROW_BITS_DEF,
    parameter int BITS       = BITS_DEF,
    parameter int BASE_TICKS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         front_buf,
    output logic [ROW_BITS+COL_BITS:0]   rd_addr,
    input  logic [NUM_CHAN*BITS-1:0]     rd_data,
    output logic                         clk_screen,
    output logic                         R0,
    output logic                         G0,
    output logic                         B0,
    output logic                         R1,
    output logic                         G1,
    output logic                         B1,
    output logic                         blank,
    output logic                         latch,
    output logic [ROW_BITS-1:0]          row,
    output logic                         frame_start
);

    localparam int PLANE_W  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int SHOW_MAX = BASE_TICKS << (BITS - 1);
    localparam int SHOW_W   = $clog2(SHOW_MAX + 1);

    localparam logic [COL_BITS:0]  COL_END    = (COL_BITS + 1)'(NUM_COLS);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITS - 1);

    if (CLK_DIV < 4 || (CLK_DIV % 2) != 0 || freq_hz < CLK_DIV) begin : g_bad_clk_div
        $error("screen_scan_ctrl: CLK_DIV must be even, >= 4 and not exceed freq_hz");
    end

    logic tick;
    logic half_tick;

    screen_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .half  (half_tick)
    );

    scan_state_e           state_q, state_d;
    logic [COL_BITS:0]     col_q, col_d;
    logic [PLANE_W-1:0]    plane_q, plane_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic                  front_q, front_d;
    logic [SHOW_W-1:0]     show_q, show_d;
    logic                  clk_scr_q, clk_scr_d;
    logic                  latch_q, latch_d;
    logic                  blank_q, blank_d;
    logic [NUM_CHAN-1:0]   rgb_q, rgb_d;
    logic                  swap_ack_q, swap_ack_d;
    logic                  frame_start_q, frame_start_d;

    logic [NUM_CHAN-1:0]   plane_bits;
    logic [SHOW_W-1:0]     show_len;

    // Pick the current bit-plane out of every colour channel of the fetched word.
    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        logic [BITS-1:0] chan;
        assign chan          = rd_data[c*BITS +: BITS];
        assign plane_bits[c] = chan[plane_q];
    end

    assign show_len = SHOW_W'(BASE_TICKS) << plane_q;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        plane_d       = plane_q;
        row_d         = row_q;
        front_d       = front_q;
        show_d        = show_q;
        clk_scr_d     = clk_scr_q;
        latch_d       = latch_q;
        blank_d       = blank_q;
        rgb_d         = rgb_q;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;

        // Rising shift edge only once a column has actually been loaded.
        if (half_tick && state_q == ST_SHIFT && col_q != '0) begin
            clk_scr_d = 1'b1;
        end

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    blank_d = 1'b1;
                    if (enable) begin
                        state_d       = ST_SHIFT;
                        col_d         = '0;
                        frame_start_d = (row_q == '0) && (plane_q == '0);
                    end
                end
                ST_SHIFT: begin
                    clk_scr_d = 1'b0;
                    if (col_q == COL_END) begin
                        state_d = ST_LATCH;
                        latch_d = 1'b1;
                        col_d   = '0;
                    end else begin
                        rgb_d = plane_bits;
                        col_d = col_q + (COL_BITS + 1)'(1);
                    end
                end
                ST_LATCH: begin
                    latch_d = 1'b0;
                    blank_d = 1'b0;
                    show_d  = '0;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (show_q == show_len - SHOW_W'(1)) begin
                        blank_d = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        show_d = show_q + SHOW_W'(1);
                    end
                end
                ST_NEXT: begin
                    col_d = '0;
                    if (plane_q != PLANE_LAST) begin
                        plane_d = plane_q + PLANE_W'(1);
                        state_d = ST_SHIFT;
                    end else begin
                        // Row boundary: the only point where enable and swap_req are honoured.
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                        if (row_q == '1 && swap_req) begin
                            front_d    = ~front_q;
                            swap_ack_d = 1'b1;
                        end
                        if (enable) begin
                            state_d       = ST_SHIFT;
                            frame_start_d = (row_q == '1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            plane_q       <= '0;
            row_q         <= '0;
            front_q       <= 1'b0;
            show_q        <= '0;
            clk_scr_q     <= 1'b0;
            latch_q       <= 1'b0;
            blank_q       <= 1'b1;
            rgb_q         <= '0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            plane_q       <= plane_d;
            row_q         <= row_d;
            front_q       <= front_d;
            show_q        <= show_d;
            clk_scr_q     <= clk_scr_d;
            latch_q       <= latch_d;
            blank_q       <= blank_d;
            rgb_q         <= rgb_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rd_addr     = {front_q, row_q, col_q[COL_BITS-1:0]};
    assign front_buf   = front_q;
    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign clk_screen  = clk_scr_q;
    assign blank       = blank_q;
    assign latch       = latch_q;
    assign row         = row_q;
    assign R0          = rgb_q[FB_R0];
    assign G0          = rgb_q[FB_G0];
    assign B0          = rgb_q[FB_B0];
    assign R1          = rgb_q[FB_R1];
    assign G1          = rgb_q[FB_G1];
    assign B1          = rgb_q[FB_B1];

endmodule

// File: tb/tb_screen_scan_ctrl.sv
// Scoreboard bench for screen_scan_ctrl: a row-level model queues the expected
// panel events and a negedge monitor matches what the panel pins show.
module tb_screen_scan_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int NUM_COLS   = 64;
    localparam int ROW_BITS   = 5;
    localparam int BITS       = 4;
    localparam int BASE_TICKS = 8;
    localparam int AW         = 1 + ROW_BITS + 6;
    localparam int DW         = 6 * BITS;
    localparam int NROWS      = 1 << ROW_BITS;
    localparam int FB_DEPTH   = 1 << AW;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic                swap_req = 1'b0;
    logic                swap_ack;
    logic                front_buf;
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       rd_data;
    logic                clk_screen;
    logic                R0, G0, B0, R1, G1, B1;
    logic                blank;
    logic                latch;
    logic [ROW_BITS-1:0] row;
    logic                frame_start;

    always #5 clk = ~clk;

    screen_scan_ctrl #(
        .freq_hz    (25000000),
        .CLK_DIV    (CLK_DIV),
        .NUM_COLS   (NUM_COLS),
        .ROW_BITS   (ROW_BITS),
        .BITS       (BITS),
        .BASE_TICKS (BASE_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .front_buf   (front_buf),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .clk_screen  (clk_screen),
        .R0          (R0),
        .G0          (G0),
        .B0          (B0),
        .R1          (R1),
        .G1          (G1),
        .B1          (B1),
        .blank       (blank),
        .latch       (latch),
        .row         (row),
        .frame_start (frame_start)
    );

    // Synchronous-read framebuffer RAM.
    logic [DW-1:0] fb [FB_DEPTH];
    always @(posedge clk) rd_data <= fb[rd_addr];

    typedef enum int {EV_SHIFT, EV_LATCH, EV_SHOW, EV_SWAP, EV_FRAME} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       row;
        int       rgb;
        int       addr;
        int       len;
        int       front;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  edges_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word layout {R0,G0,B0,R1,G1,B1}, each BITS wide, R0 in the top slot.
    function automatic int pix_bits(input int f, input int r, input int c, input int p);
        logic [DW-1:0] w;
        int            res;
        w   = fb[AW'((f << (ROW_BITS + 6)) | (r << 6) | c)];
        res = 0;
        for (int ch = 5; ch >= 0; ch--) res = (res << 1) | int'((w >> (ch * BITS + p)) & DW'(1));
        return res;
    endfunction

    task automatic push_ev(input ev_kind_e k, input int r, input int f);
        ev_t e;
        e = '{kind: k, row: r, rgb: 0, addr: 0, len: 0, front: f};
        exp_q.push_back(e);
    endtask

    // One row: every plane shifts all columns, latches for one tick, then shows
    // for BASE_TICKS<<plane ticks. rd_addr has already moved to the next column
    // (6-bit field) when the shift clock rises.
    task automatic push_row(input int f, input int r);
        ev_t e;
        for (int p = 0; p < BITS; p++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                e = '{kind: EV_SHIFT, row: r, rgb: pix_bits(f, r, c, p),
                      addr: (f << (ROW_BITS + 6)) | (r << 6) | ((c + 1) & 63), len: 0, front: f};
                exp_q.push_back(e);
            end
            e = '{kind: EV_LATCH, row: r, rgb: 0, addr: 0, len: CLK_DIV, front: f};
            exp_q.push_back(e);
            e = '{kind: EV_SHOW, row: r, rgb: 0, addr: 0, len: (BASE_TICKS << p) * CLK_DIV, front: f};
            exp_q.push_back(e);
        end
    endtask

    task automatic take(input ev_kind_e k, input int rgb, input int addr, input int len);
        ev_t e;
        chk({"event_expected_", k.name()}, int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        if (k != e.kind) return;
        case (k)
            EV_SHIFT: begin
                chk("shift_row", int'(row), e.row);
                chk("shift_rgb", rgb, e.rgb);
                chk("shift_addr", addr, e.addr);
            end
            EV_LATCH: begin
                chk("latch_len", len, e.len);
                chk("latch_row", int'(row), e.row);
            end
            EV_SHOW: begin
                chk("show_len", len, e.len);
                chk("show_row", int'(row), e.row);
            end
            EV_SWAP:  chk("swap_front", int'(front_buf), e.front);
            default:  chk("frame_row", int'(row), e.row);
        endcase
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic                prev_clk, prev_latch, prev_blank;
    logic [ROW_BITS-1:0] prev_row;
    int                  latch_len, blank_len;

    always @(negedge clk) begin
        if (reset) begin
            prev_clk   = 1'b0;
            prev_latch = 1'b0;
            prev_blank = 1'b1;
            prev_row   = row;
            latch_len  = 0;
            blank_len  = 0;
        end else begin
            if (swap_ack) take(EV_SWAP, 0, 0, 0);
            if (frame_start) take(EV_FRAME, 0, 0, 0);
            if (clk_screen && !prev_clk) begin
                edges_seen++;
                take(EV_SHIFT, int'({R0, G0, B0, R1, G1, B1}), int'(rd_addr), 0);
            end
            if (latch) latch_len++;
            else if (prev_latch) begin
                take(EV_LATCH, 0, 0, latch_len);
                latch_len = 0;
            end
            if (!blank) blank_len++;
            else if (!prev_blank) begin
                take(EV_SHOW, 0, 0, blank_len);
                blank_len = 0;
            end
            if (row != prev_row) chk("row_change_blanked", int'({prev_blank, blank}), 3);
            prev_clk   = clk_screen;
            prev_latch = latch;
            prev_blank = blank;
            prev_row   = row;
        end
    end

    task automatic wait_edges(input int target, input int budget, input string what);
        int n = 0;
        while (edges_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({what, "_reached"}, int'(edges_seen >= target), 1);
    endtask

    task automatic wait_drain(input int budget, input string what);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({what, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_blank"}, int'(blank), 1);
        chk({tag, "_latch"}, int'(latch), 0);
        chk({tag, "_clk_screen"}, int'(clk_screen), 0);
        chk({tag, "_rgb"}, int'({R0, G0, B0, R1, G1, B1}), 0);
        chk({tag, "_row"}, int'(row), 0);
        chk({tag, "_front_buf"}, int'(front_buf), 0);
        chk({tag, "_swap_ack"}, int'(swap_ack), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
        $fatal(1, "tb_screen_scan_ctrl: watchdog");
    end

    initial begin
        int base;
        int stop_row;
        int swap_row;
        int idle_edges;
        int n;

        for (int a = 0; a < FB_DEPTH; a++) fb[a] = DW'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        // Run from row 0, then drop enable partway through row 5 plane 1.
        stop_row = 5;
        push_ev(EV_FRAME, 0, 0);
        for (int r = 0; r <= stop_row; r++) push_row(0, r);
        enable = 1'b1;
        base = edges_seen;
        wait_edges(base + (stop_row * BITS + 1) * NUM_COLS + int'($urandom_range(1, 60)), 20000, "row5_plane1");
        enable = 1'b0;
        wait_drain(20000, "stop");
        repeat (50 * CLK_DIV) @(posedge clk);
        #1;
        idle_edges = edges_seen;
        chk("idle_row", int'(row), stop_row + 1);
        chk("idle_blank", int'(blank), 1);
        chk("idle_latch", int'(latch), 0);
        repeat (40 * CLK_DIV) @(posedge clk);
        #1;
        chk("idle_no_edges", edges_seen, idle_edges);
        chk("idle_clk_screen", int'(clk_screen), 0);

        // Resume, request a swap mid-frame; it must land exactly at the 31->0 wrap.
        for (int r = stop_row + 1; r < NROWS; r++) push_row(0, r);
        push_ev(EV_SWAP, 0, 1);
        push_ev(EV_FRAME, 0, 1);
        push_row(1, 0);
        push_row(1, 1);
        enable = 1'b1;
        base = edges_seen;
        swap_row = int'($urandom_range(8, 20));
        wait_edges(base + (swap_row - stop_row - 1) * BITS * NUM_COLS + 10, 30000, "swap_req_row");
        swap_req = 1'b1;
        chk("no_early_swap", int'(front_buf), 0);
        n = 0;
        while (swap_ack !== 1'b1 && n < 50000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("swap_ack_seen", int'(swap_ack), 1);
        chk("front_after_swap", int'(front_buf), 1);
        chk("row_at_swap", int'(row), 0);
        swap_req = 1'b0;

        // Reset while row 1 (front buffer 1) is showing plane 0.
        base = edges_seen;
        wait_edges(base + (BITS + 1) * NUM_COLS, 5000, "row1_plane0");
        n = 0;
        while (blank !== 1'b0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_show", int'(blank), 0);
        chk("pre_reset_row", int'(row), 1);
        chk("pre_reset_front", int'(front_buf), 1);
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        push_ev(EV_FRAME, 0, 0);
        push_row(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Normal restart from row 0 on buffer 0, then stop after that row.
        base = edges_seen;
        wait_edges(base + int'($urandom_range(5, 50)), 2000, "restart");
        enable = 1'b0;
        wait_drain(5000, "restart");
        repeat (50 * CLK_DIV) @(posedge clk);
        #1;
        chk("restart_idle_row", int'(row), 1);
        chk("restart_idle_blank", int'(blank), 1);
        chk("restart_front", int'(front_buf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
